// File: rtl/rf_port_arbiter_if.sv
// rf_port_arbiter_if: lane-side and physical-regfile-side signals of rf_port_arbiter.
// slave  = arbiter view; master = issue lanes plus the widened regfile relay.
interface rf_port_arbiter_if #(
   parameter int XLEN = 64
);
   // Lane read requests and results
   logic            RdReq0, RdReq1;
   logic [4:0]      Rs1_0, Rs2_0, Rs1_1, Rs2_1;
   logic            RdGnt0, RdGnt1;
   logic [XLEN-1:0] RData1_0, RData2_0, RData1_1, RData2_1;
   // Lane write requests
   logic            WrValid0, WrValid1;
   logic [4:0]      WrAdr0, WrAdr1;
   logic [XLEN-1:0] WrData0, WrData1;
   logic            WrReady0, WrReady1;
   // Physical register file ports
   logic [4:0]      a1, a2;
   logic [XLEN-1:0] rd1, rd2;
   logic            we3;
   logic [4:0]      a3;
   logic [XLEN-1:0] wd3;
   logic            WBufEmpty;

   modport slave (
      input  RdReq0, RdReq1, Rs1_0, Rs2_0, Rs1_1, Rs2_1,
             WrValid0, WrValid1, WrAdr0, WrAdr1, WrData0, WrData1, rd1, rd2,
      output RdGnt0, RdGnt1, RData1_0, RData2_0, RData1_1, RData2_1,
             WrReady0, WrReady1, a1, a2, we3, a3, wd3, WBufEmpty
   );

   modport master (
      output RdReq0, RdReq1, Rs1_0, Rs2_0, Rs1_1, Rs2_1,
             WrValid0, WrValid1, WrAdr0, WrAdr1, WrData0, WrData1, rd1, rd2,
      input  RdGnt0, RdGnt1, RData1_0, RData2_0, RData1_1, RData2_1,
             WrReady0, WrReady1, a1, a2, we3, a3, wd3, WBufEmpty
   );
endinterface

// File: rtl/rf_port_arbiter.sv
// rf_port_arbiter: shares a 2R/1W integer register file between two issue lanes.
// Reads are arbitrated round-robin on port over-subscription; writes go through a
// small FIFO drained one entry per cycle, with youngest-entry bypass to readers.
// Optional statistics counters are enabled by defining RF_ARB_STATS_EN.
module rf_port_arbiter #(
   parameter int XLEN       = 64,
   parameter int WBUF_DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   rf_port_arbiter_if.slave bus
`ifdef RF_ARB_STATS_EN
   ,
   output logic [31:0]      ConflictCnt,
   output logic [31:0]      WrStallCnt
`endif
);
   localparam int AW = $clog2(WBUF_DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic {PREF_LANE0 = 1'b0, PREF_LANE1 = 1'b1} rr_e;

   rr_e             r_rr_ptr, w_rr_nxt;
   logic [CW-1:0]   r_count, w_count_nxt, w_free, w_rem, w_enq_n, w_drain_n;
   logic [AW-1:0]   r_head, r_tail, w_head_nxt, w_tail1;
   logic [4:0]      r_fifo_adr  [WBUF_DEPTH];
   logic [XLEN-1:0] r_fifo_data [WBUF_DEPTH];
   logic            r_we3, w_we3_nxt;
   logic [4:0]      r_a3, w_a3_nxt;
   logic [XLEN-1:0] r_wd3, w_wd3_nxt;

   logic [1:0]      w_dem0, w_dem1, w_used;
   logic [2:0]      w_dem_tot;
   logic            w_conflict, w_gnt0, w_gnt1;
   logic [4:0]      w_op_adr  [4];
   logic            w_op_port [4];
   logic [XLEN-1:0] w_op_data [4];
   logic [4:0]      w_a1, w_a2;

   logic            w_drain, w_need0, w_need1, w_acc0, w_acc1, w_rdy0, w_rdy1;

   // ---------------- read arbitration ----------------
   assign w_dem0     = bus.RdReq0 ? ({1'b0, bus.Rs1_0 != 5'd0} + {1'b0, bus.Rs2_0 != 5'd0}) : 2'd0;
   assign w_dem1     = bus.RdReq1 ? ({1'b0, bus.Rs1_1 != 5'd0} + {1'b0, bus.Rs2_1 != 5'd0}) : 2'd0;
   assign w_dem_tot  = {1'b0, w_dem0} + {1'b0, w_dem1};
   assign w_conflict = reset && (w_dem_tot > 3'd2);
   assign w_gnt0     = reset && bus.RdReq0 && (!w_conflict || (r_rr_ptr == PREF_LANE0));
   assign w_gnt1     = reset && bus.RdReq1 && (!w_conflict || (r_rr_ptr == PREF_LANE1));

   // Operand order fixes port priority: lane 0 Rs1, Rs2, then lane 1 Rs1, Rs2.
   assign w_op_adr[0] = bus.Rs1_0;
   assign w_op_adr[1] = bus.Rs2_0;
   assign w_op_adr[2] = bus.Rs1_1;
   assign w_op_adr[3] = bus.Rs2_1;

   // Preferred-lane register; it moves only on conflict cycles.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_rr_ptr <= PREF_LANE0;
      else        r_rr_ptr <= w_rr_nxt;
   end

   // Next preferred lane: hand the ports to the other lane after a conflict.
   // NOTE: every signal written here gets a default first, otherwise a latch is inferred.
   always_comb begin
      w_rr_nxt = r_rr_ptr;
      if (w_conflict) w_rr_nxt = (r_rr_ptr == PREF_LANE0) ? PREF_LANE1 : PREF_LANE0;
   end

   // Assign granted nonzero operands to a1 then a2; unused ports read x0.
   always_comb begin
      w_a1   = '0;
      w_a2   = '0;
      w_used = '0;
      for (int i = 0; i < 4; i++) begin
         w_op_port[i] = 1'b0;
         if (((i < 2) ? w_gnt0 : w_gnt1) && (w_op_adr[i] != 5'd0)) begin
            if (w_used == 2'd0) begin
               w_a1 = w_op_adr[i];
            end else begin
               w_a2          = w_op_adr[i];
               w_op_port[i]  = 1'b1;
            end
            w_used = w_used + 2'd1;
         end
      end
   end

   // Operand data: x0 reads zero, else youngest buffered write, else physical port.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         w_op_data[i] = '0;
         if (w_op_adr[i] != 5'd0) begin
            w_op_data[i] = w_op_port[i] ? bus.rd2 : bus.rd1;
            for (int j = 0; j < WBUF_DEPTH; j++) begin
               if ((CW'(j) < r_count) && (r_fifo_adr[r_head + AW'(j)] == w_op_adr[i]))
                  w_op_data[i] = r_fifo_data[r_head + AW'(j)];
            end
         end
      end
   end

   // ---------------- write buffer ----------------
   // x0 writes are acknowledged without consuming a slot.
   assign w_drain     = (r_count != '0);
   assign w_drain_n   = {{(CW-1){1'b0}}, w_drain};
   assign w_free      = CW'(WBUF_DEPTH) - r_count + w_drain_n;
   assign w_need0     = bus.WrValid0 && (bus.WrAdr0 != 5'd0);
   assign w_need1     = bus.WrValid1 && (bus.WrAdr1 != 5'd0);
   assign w_acc0      = reset && w_need0 && (w_free != '0);
   assign w_acc1      = reset && w_need1 && ((w_free >= CW'(2)) || ((w_free == CW'(1)) && !w_need0));
   assign w_rdy0      = reset && bus.WrValid0 && ((bus.WrAdr0 == 5'd0) || w_acc0);
   assign w_rdy1      = reset && bus.WrValid1 && ((bus.WrAdr1 == 5'd0) || w_acc1);
   assign w_enq_n     = {{(CW-1){1'b0}}, w_acc0} + {{(CW-1){1'b0}}, w_acc1};
   assign w_count_nxt = r_count + w_enq_n - w_drain_n;
   assign w_rem       = r_count - w_drain_n;
   assign w_head_nxt  = r_head + AW'(w_drain);
   assign w_tail1     = r_tail + AW'(w_acc0);

   // Pick the entry that will be at the head next cycle, so we3/a3/wd3 are a
   // registered copy of the head and the entry stays bypassable until it lands.
   always_comb begin
      w_we3_nxt = 1'b0;
      w_a3_nxt  = '0;
      w_wd3_nxt = '0;
      if (w_rem != '0) begin
         w_we3_nxt = 1'b1;
         w_a3_nxt  = r_fifo_adr[w_head_nxt];
         w_wd3_nxt = r_fifo_data[w_head_nxt];
      end else if (w_acc0) begin
         w_we3_nxt = 1'b1;
         w_a3_nxt  = bus.WrAdr0;
         w_wd3_nxt = bus.WrData0;
      end else if (w_acc1) begin
         w_we3_nxt = 1'b1;
         w_a3_nxt  = bus.WrAdr1;
         w_wd3_nxt = bus.WrData1;
      end
   end

   // Buffer pointers, occupancy and the registered physical write port.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_count <= '0;
         r_head  <= '0;
         r_tail  <= '0;
         r_we3   <= 1'b0;
         r_a3    <= '0;
         r_wd3   <= '0;
      end else begin
         r_count <= w_count_nxt;
         r_head  <= w_head_nxt;
         r_tail  <= r_tail + AW'(w_acc0) + AW'(w_acc1);
         r_we3   <= w_we3_nxt;
         r_a3    <= w_a3_nxt;
         r_wd3   <= w_wd3_nxt;
      end
   end

   // Buffer storage: lane 0 lands at the tail, lane 1 right behind it.
   // NOTE: storage is deliberately not reset; r_count/r_head qualify every read of it.
   always_ff @(posedge clk) begin
      if (w_acc0) begin
         r_fifo_adr[r_tail]   <= bus.WrAdr0;
         r_fifo_data[r_tail]  <= bus.WrData0;
      end
      if (w_acc1) begin
         r_fifo_adr[w_tail1]  <= bus.WrAdr1;
         r_fifo_data[w_tail1] <= bus.WrData1;
      end
   end

   assign bus.RdGnt0    = w_gnt0;
   assign bus.RdGnt1    = w_gnt1;
   assign bus.RData1_0  = w_op_data[0];
   assign bus.RData2_0  = w_op_data[1];
   assign bus.RData1_1  = w_op_data[2];
   assign bus.RData2_1  = w_op_data[3];
   assign bus.a1        = w_a1;
   assign bus.a2        = w_a2;
   assign bus.WrReady0  = w_rdy0;
   assign bus.WrReady1  = w_rdy1;
   assign bus.we3       = r_we3;
   assign bus.a3        = r_a3;
   assign bus.wd3       = r_wd3;
   assign bus.WBufEmpty = (r_count == '0);

`ifdef RF_ARB_STATS_EN
   logic [31:0] r_conflict_cnt, r_stall_cnt;
   logic        w_stall;

   assign w_stall = (bus.WrValid0 && !w_rdy0) || (bus.WrValid1 && !w_rdy1);

   // Saturating event counters for read conflicts and write stalls.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_conflict_cnt <= '0;
         r_stall_cnt    <= '0;
      end else begin
         if (w_conflict && (r_conflict_cnt != '1)) r_conflict_cnt <= r_conflict_cnt + 32'd1;
         if (w_stall && (r_stall_cnt != '1))       r_stall_cnt    <= r_stall_cnt + 32'd1;
      end
   end

   assign ConflictCnt = r_conflict_cnt;
   assign WrStallCnt  = r_stall_cnt;
`endif
endmodule

// File: tb/tb_rf_port_arbiter.sv
// tb_rf_port_arbiter: directed stimulus with queued expectations; a negedge
// monitor pops and compares whenever the DUT is asked for a read or write
// result, or presents a physical write.
module tb_rf_port_arbiter;
   localparam int XLEN = 64;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   rf_port_arbiter_if #(.XLEN(XLEN)) bus ();

`ifdef RF_ARB_STATS_EN
   logic [31:0] conflict_cnt, wr_stall_cnt;
`endif

   rf_port_arbiter #(.XLEN(XLEN), .WBUF_DEPTH(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
`ifdef RF_ARB_STATS_EN
      ,
      .ConflictCnt (conflict_cnt),
      .WrStallCnt  (wr_stall_cnt)
`endif
   );

   // Physical register file: combinational reads, x0 hardwired, xN preset to 0x1000+N.
   logic [XLEN-1:0] rf_mem [32];
   logic            rf_init_done = 1'b0;
   always @(posedge clk) begin
      if (!rf_init_done) begin
         for (int i = 0; i < 32; i++) rf_mem[i] <= (i == 0) ? 64'd0 : 64'h1000 + 64'(i);
         rf_init_done <= 1'b1;
      end else if (bus.we3 && (bus.a3 != 5'd0)) begin
         rf_mem[bus.a3] <= bus.wd3;
      end
   end
   assign bus.rd1 = rf_mem[bus.a1];
   assign bus.rd2 = rf_mem[bus.a2];

   typedef struct packed {
      logic        g0, g1;
      logic [4:0]  a1, a2;
      logic [63:0] d10, d20, d11, d21;
   } rd_exp_t;
   typedef struct packed { logic r0, r1; } wr_exp_t;
   typedef struct packed { logic [4:0] a; logic [63:0] d; } we_exp_t;

   rd_exp_t rd_q[$];
   wr_exp_t wr_q[$];
   we_exp_t we_q[$];
   rd_exp_t m_rd;
   wr_exp_t m_wr;
   we_exp_t m_we;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic flag(input string name);
      checks++;
      errors++;
      $display("FAIL %s", name);
   endtask

   task automatic clear_inputs();
      bus.RdReq0 = 1'b0; bus.RdReq1 = 1'b0;
      bus.Rs1_0  = '0;   bus.Rs2_0  = '0;   bus.Rs1_1 = '0; bus.Rs2_1 = '0;
      bus.WrValid0 = 1'b0; bus.WrValid1 = 1'b0;
      bus.WrAdr0 = '0;   bus.WrAdr1 = '0;
      bus.WrData0 = '0;  bus.WrData1 = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      clear_inputs();
   endtask

   task automatic rd(input logic q0, input logic [4:0] s10, input logic [4:0] s20,
                     input logic q1, input logic [4:0] s11, input logic [4:0] s21,
                     input logic g0, input logic g1, input logic [4:0] ea1, input logic [4:0] ea2,
                     input logic [63:0] d10, input logic [63:0] d20,
                     input logic [63:0] d11, input logic [63:0] d21);
      rd_exp_t e;
      bus.RdReq0 = q0; bus.Rs1_0 = s10; bus.Rs2_0 = s20;
      bus.RdReq1 = q1; bus.Rs1_1 = s11; bus.Rs2_1 = s21;
      e.g0 = g0; e.g1 = g1; e.a1 = ea1; e.a2 = ea2;
      e.d10 = d10; e.d20 = d20; e.d11 = d11; e.d21 = d21;
      rd_q.push_back(e);
   endtask

   task automatic wr(input logic v0, input logic [4:0] adr0, input logic [63:0] dat0,
                     input logic v1, input logic [4:0] adr1, input logic [63:0] dat1,
                     input logic r0, input logic r1);
      wr_exp_t e;
      bus.WrValid0 = v0; bus.WrAdr0 = adr0; bus.WrData0 = dat0;
      bus.WrValid1 = v1; bus.WrAdr1 = adr1; bus.WrData1 = dat1;
      e.r0 = r0; e.r1 = r1;
      wr_q.push_back(e);
   endtask

   task automatic expw(input logic [4:0] a, input logic [63:0] d);
      we_exp_t e;
      e.a = a; e.d = d;
      we_q.push_back(e);
   endtask

   // Monitor: compare every presented read/write result against the queues.
   always @(negedge clk) begin
      if (reset === 1'b1) begin
         if (bus.RdReq0 || bus.RdReq1) begin
            if (rd_q.size() == 0) flag("rd_unexpected_request");
            else begin
               m_rd = rd_q.pop_front();
               check("rd_gnt0", bus.RdGnt0, m_rd.g0);
               check("rd_gnt1", bus.RdGnt1, m_rd.g1);
               check("rd_a1", bus.a1, m_rd.a1);
               check("rd_a2", bus.a2, m_rd.a2);
               if (m_rd.g0) begin
                  check("rdata1_0", bus.RData1_0, m_rd.d10);
                  check("rdata2_0", bus.RData2_0, m_rd.d20);
               end
               if (m_rd.g1) begin
                  check("rdata1_1", bus.RData1_1, m_rd.d11);
                  check("rdata2_1", bus.RData2_1, m_rd.d21);
               end
            end
         end else if (bus.RdGnt0 || bus.RdGnt1) begin
            flag("rd_grant_without_request");
         end
         if (bus.WrValid0 || bus.WrValid1) begin
            if (wr_q.size() == 0) flag("wr_unexpected_request");
            else begin
               m_wr = wr_q.pop_front();
               check("wr_ready0", bus.WrReady0, m_wr.r0);
               check("wr_ready1", bus.WrReady1, m_wr.r1);
            end
         end else if (bus.WrReady0 || bus.WrReady1) begin
            flag("wr_ready_without_valid");
         end
         if (bus.we3) begin
            if (we_q.size() == 0) begin
               $display("FAIL we3_unexpected: got a3=%0d wd3=%0h with nothing expected", bus.a3, bus.wd3);
               checks++;
               errors++;
            end else begin
               m_we = we_q.pop_front();
               check("we3_a3", bus.a3, m_we.a);
               check("we3_wd3", bus.wd3, m_we.d);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      clear_inputs();
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      // Requests during reset must see no grant and no ready.
      bus.RdReq0 = 1'b1; bus.Rs1_0 = 5'd5; bus.RdReq1 = 1'b1; bus.Rs1_1 = 5'd6;
      bus.WrValid0 = 1'b1; bus.WrAdr0 = 5'd3; bus.WrValid1 = 1'b1; bus.WrAdr1 = 5'd4;
      #1;
      check("rst_gnt0", bus.RdGnt0, 1'b0);
      check("rst_gnt1", bus.RdGnt1, 1'b0);
      check("rst_rdy0", bus.WrReady0, 1'b0);
      check("rst_rdy1", bus.WrReady1, 1'b0);
      check("rst_we3", bus.we3, 1'b0);
      check("rst_a3", bus.a3, 5'd0);
      check("rst_wd3", bus.wd3, 64'd0);
      check("rst_empty", bus.WBufEmpty, 1'b1);
      clear_inputs();
      @(negedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1;
`ifdef RF_ARB_STATS_EN
      check("stats_conflict_init", conflict_cnt, 32'd0);
      check("stats_stall_init", wr_stall_cnt, 32'd0);
`endif

      // C0: total demand 2 -> both granted, lane 1 x0 operands read zero.
      rd(1, 5, 6, 1, 0, 0, 1, 1, 5, 6, 64'h1005, 64'h1006, 64'd0, 64'd0); step();
      // C1..C3: demand 4 -> lane0, lane1, lane0.
      rd(1, 1, 2, 1, 3, 4, 1, 0, 1, 2, 64'h1001, 64'h1002, 64'd0, 64'd0); step();
      rd(1, 1, 2, 1, 3, 4, 0, 1, 3, 4, 64'd0, 64'd0, 64'h1003, 64'h1004); step();
      rd(1, 1, 2, 1, 3, 4, 1, 0, 1, 2, 64'h1001, 64'h1002, 64'd0, 64'd0); step();

      // C4: lane0 writes x7; C5 bypass read; C6 physical read after drain.
      wr(1, 7, 64'hAA, 0, 0, 64'd0, 1, 0); expw(7, 64'hAA); step();
      check("empty_after_enq", bus.WBufEmpty, 1'b0);
      rd(0, 0, 0, 1, 7, 0, 0, 1, 7, 0, 64'd0, 64'd0, 64'hAA, 64'd0); step();
      check("empty_after_drain", bus.WBufEmpty, 1'b1);
      rd(0, 0, 0, 1, 7, 0, 0, 1, 7, 0, 64'd0, 64'd0, 64'hAA, 64'd0); step();

      // C7: both lanes write x9; younger lane 1 wins the bypass in C8.
      wr(1, 9, 64'h11, 1, 9, 64'h22, 1, 1); expw(9, 64'h11); expw(9, 64'h22); step();
      rd(1, 9, 0, 0, 0, 0, 1, 0, 9, 0, 64'h22, 64'd0, 64'd0, 64'd0); step();
      step();

      // C10..C15: fill the buffer with paired writes, then free==1 favours lane 0.
      wr(1, 10, 64'hA0, 1, 11, 64'hB0, 1, 1); expw(10, 64'hA0); expw(11, 64'hB0); step();
      wr(1, 12, 64'hC0, 1, 13, 64'hD0, 1, 1); expw(12, 64'hC0); expw(13, 64'hD0); step();
      wr(1, 14, 64'hE0, 1, 15, 64'hF0, 1, 1); expw(14, 64'hE0); expw(15, 64'hF0); step();
      wr(1, 16, 64'h160, 1, 17, 64'h170, 1, 0); expw(16, 64'h160); step();
      wr(1, 18, 64'h180, 1, 17, 64'h170, 1, 0); expw(18, 64'h180); step();
      wr(0, 0, 64'd0, 1, 17, 64'h170, 0, 1); expw(17, 64'h170); step();
      // C16: write to x0 is acknowledged and never reaches we3.
      wr(1, 0, 64'hDEAD, 0, 0, 64'd0, 1, 0); step();

      // C17: three entries buffered; reset drops them.
      check("empty_before_reset", bus.WBufEmpty, 1'b0);
      check("rf_x15_landed", rf_mem[15], 64'hF0);
`ifdef RF_ARB_STATS_EN
      check("stats_conflict", conflict_cnt, 32'd3);
      check("stats_stall", wr_stall_cnt, 32'd2);
`endif
      #1 reset = 1'b0;
      we_q.delete();
      #1;
      check("mid_rst_we3", bus.we3, 1'b0);
      check("mid_rst_empty", bus.WBufEmpty, 1'b1);
      check("mid_rst_a3", bus.a3, 5'd0);
`ifdef RF_ARB_STATS_EN
      check("stats_conflict_rst", conflict_cnt, 32'd0);
      check("stats_stall_rst", wr_stall_cnt, 32'd0);
`endif
      @(negedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1;
      repeat (3) step();
      check("no_stale_x16", rf_mem[16], 64'h1010);
      check("no_stale_x17", rf_mem[17], 64'h1011);
      check("no_stale_x18", rf_mem[18], 64'h1012);

      // Round-robin pointer is back at lane 0 after reset.
      rd(1, 1, 2, 1, 3, 4, 1, 0, 1, 2, 64'h1001, 64'h1002, 64'd0, 64'd0); step();
      rd(1, 10, 0, 0, 0, 0, 1, 0, 10, 0, 64'hA0, 64'd0, 64'd0, 64'd0); step();
      repeat (2) step();

      check("rd_q_drained", rd_q.size(), 0);
      check("wr_q_drained", wr_q.size(), 0);
      check("we_q_drained", we_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
